mem_port_arbiter: RTL

- Shares one single-ported, fixed-latency RAM request port between NUM_PORTS requesters, each using the team's valid/data/ack handshake.
- Round-robin arbitration with zero-cycle forwarding: a requester's word reaches the memory in the same cycle it is offered, and a memory ack retires it in that same cycle.
- A latency-matched ID pipeline routes read responses back to the issuing requester.
- Sits between the skid-style per-channel memory buffers and the shared RAM.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_priority_select.sv | 35 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the ID-pipeline stage record and the grant-counter width.
package mem_arb_pkg;

  localparam int GRANT_COUNT_WIDTH = 16;

  // One slot of the response-routing pipeline; id is wide enough for any legal port count.
  typedef struct packed {
    logic        valid;
    logic [15:0] id;
  } pipe_stage_t;

  function automatic int id_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first asserted req at or above rr_ptr, wrapping modulo NUM_PORTS.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; grant is a pure function of req and rr_ptr.
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  rr_ptr,
  output logic [ID_WIDTH-1:0]  grant,
  output logic                 any_valid
);

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [ID_WIDTH-1:0]    offset;
  logic [ID_WIDTH:0]      grant_sum;

  always_comb begin
    // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner's distance.
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_PORTS-1:0];
    offset  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = ID_WIDTH'(k);
    end
    grant_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (grant_sum >= (ID_WIDTH + 1)'(NUM_PORTS)) begin
      grant_sum = grant_sum - (ID_WIDTH + 1)'(NUM_PORTS);
    end
    grant     = grant_sum[ID_WIDTH-1:0];
    any_valid = |req;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one fixed-latency RAM port; responses routed back by an ID pipe.
// Latency: 0 cycles request forward/ack; responses strobe MEM_LATENCY cycles after accept.
// Backpressure: mem_ack low locks the grant so mem_data/mem_id hold until accepted.
// Optional MEM_ARB_GRANT_COUNT_EN adds per-port saturating accept counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  // Derived from NUM_PORTS; keep at its default.
  parameter int ID_WIDTH    = id_width(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ack,
  output logic                            mem_valid,
  output logic [DATA_WIDTH-1:0]           mem_data,
  output logic [ID_WIDTH-1:0]             mem_id,
  input  logic                            mem_ack,
  input  logic                            rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]           rsp_data_in,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data
`ifdef MEM_ARB_GRANT_COUNT_EN
  ,
  input  logic                                      count_clear,
  output logic [NUM_PORTS*GRANT_COUNT_WIDTH-1:0]    grant_count
`endif
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
    $error("mem_port_arbiter: NUM_PORTS must be 2..16");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
  end

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] locked_id;
  logic                locked;
  logic [ID_WIDTH-1:0] sel_grant;
  logic                sel_any_vld;
  logic [ID_WIDTH-1:0] grant;
  logic                accept;
  logic [DATA_WIDTH-1:0] grant_dat;
  pipe_stage_t         stage_in;
  pipe_stage_t         id_pipe [MEM_LATENCY];
  pipe_stage_t         pipe_last;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_select (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (sel_grant),
    .any_valid (sel_any_vld)
  );

  // A stalled request keeps its slot so a later, higher-priority arrival cannot disturb it.
  assign grant     = locked ? locked_id : sel_grant;
  assign mem_valid = locked || sel_any_vld;
  assign accept    = mem_valid && mem_ack;

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == ID_WIDTH'(i)) grant_dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mem_data = mem_valid ? grant_dat : '0;
  assign mem_id   = mem_valid ? grant : '0;

  always_comb begin
    req_ack = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ack[i] = accept && (grant == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      locked    <= 1'b0;
      locked_id <= '0;
    end else if (accept) begin
      locked <= 1'b0;
      rr_ptr <= (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
    end else if (mem_valid) begin
      locked    <= 1'b1;
      locked_id <= grant;
    end
  end

  assign stage_in = '{valid: accept, id: 16'(grant)};

  // Shifts every cycle so the tail lines up with the RAM's fixed response latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < MEM_LATENCY; s++) id_pipe[s] <= '0;
    end else begin
      id_pipe[0] <= stage_in;
      for (int s = 1; s < MEM_LATENCY; s++) id_pipe[s] <= id_pipe[s-1];
    end
  end

  assign pipe_last = id_pipe[MEM_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rsp_valid[i] = rsp_valid_in && pipe_last.valid && (pipe_last.id == 16'(i));
    end
  end

  assign rsp_data = rsp_data_in;

`ifdef MEM_ARB_GRANT_COUNT_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    logic [GRANT_COUNT_WIDTH-1:0] cnt;

    // Clear takes precedence over a same-cycle accept; counts stick at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (count_clear) begin
        cnt <= '0;
      end else if (req_ack[p] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign grant_count[p*GRANT_COUNT_WIDTH +: GRANT_COUNT_WIDTH] = cnt;
  end
`endif

endmodule
